// File: rtl/queued_note_player.sv
// Note sequencer: plays queued (note, duration) pairs as a phase-accumulated sine stream.
// Define NOTE_PLAYER_QUEUE_EN for a QDEPTH-entry note FIFO; otherwise notes are accepted only while idle.
module queued_note_player #(
    parameter int NOTE_W   = 6,
    parameter int DUR_W    = 6,
    parameter int STEP_W   = 20,
    parameter int PHASE_W  = 22,
    parameter int SINE_AW  = 10,
    parameter int SAMPLE_W = 16,
    parameter int QDEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       play_enable,
    input  logic                       flush,
    input  logic [NOTE_W-1:0]          note_in,
    input  logic [DUR_W-1:0]           duration_in,
    input  logic                       note_valid,
    output logic                       note_ready,
    input  logic                       beat,
    output logic                       note_done,
    output logic                       busy,
    output logic [NOTE_W-1:0]          freq_addr,
    input  logic [STEP_W-1:0]          step_size,
    input  logic                       generate_next_sample,
    output logic [SINE_AW-1:0]         sine_addr,
    input  logic signed [SAMPLE_W-1:0] sine_data,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       new_sample_ready
);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

    if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_qdepth
        $error("QDEPTH must be a power of two and at least 2");
    end

    state_t                     state_q, state_d;
    logic [NOTE_W-1:0]          note_q, note_d;
    logic [DUR_W-1:0]           cnt_q, cnt_d;
    logic [STEP_W-1:0]          step_q, step_d, step_cur;
    logic                       fresh_q, fresh_d;
    logic [PHASE_W-1:0]         phase_q, phase_d;
    logic                       vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic                       rest_p1_q, rest_p1_d, rest_p2_q, rest_p2_d;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d, sample_now;

    logic              avail, take, last, done_c, req, out_vld;
    logic [NOTE_W-1:0] src_note;
    logic [DUR_W-1:0]  src_dur;

`ifdef NOTE_PLAYER_QUEUE_EN
    localparam int QAW = $clog2(QDEPTH);

    logic [NOTE_W+DUR_W-1:0] mem_q [QDEPTH];
    logic [QAW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                    full, empty, push;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[QAW] != rd_ptr_q[QAW]) &&
                        (wr_ptr_q[QAW-1:0] == rd_ptr_q[QAW-1:0]);
    assign note_ready = reset && !full;
    assign push       = note_valid && note_ready && !flush;
    assign avail      = !empty;
    assign {src_note, src_dur} = mem_q[rd_ptr_q[QAW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (QAW+1)'(push);
        rd_ptr_d = rd_ptr_q + (QAW+1)'(take);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[QAW-1:0]] <= {note_in, duration_in};
    end
`else
    assign note_ready = reset && (state_q == IDLE) && play_enable;
    assign avail      = note_valid && note_ready;
    assign src_note   = note_in;
    assign src_dur    = duration_in;
`endif

    // A duration of 0 ends on the first beat, exactly like a duration of 1.
    assign last = (cnt_q <= DUR_W'(1));
    assign take = !flush && play_enable && avail &&
                  ((state_q == IDLE) || (state_q == PLAY && beat && last));

    // The frequency ROM answers one cycle after freq_addr moves, so the first PLAY cycle uses it live.
    assign step_cur = fresh_q ? step_size : step_q;
    assign req      = generate_next_sample && play_enable && (state_q == PLAY);

    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        fresh_d = fresh_q;
        phase_d = phase_q;
        done_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (take) begin
                    note_d  = src_note;
                    cnt_d   = src_dur;
                    phase_d = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (play_enable) begin
                    fresh_d = 1'b1;
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (fresh_q) begin
                    step_d  = step_size;
                    fresh_d = 1'b0;
                end
                if (play_enable && beat) begin
                    if (last) begin
                        done_c = 1'b1;
                        if (take) begin
                            note_d  = src_note;
                            cnt_d   = src_dur;
                            state_d = LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - DUR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Phase runs on across queued notes so back-to-back notes join without a jump.
        if (req) phase_d = phase_q + PHASE_W'(step_cur);
        if (flush) begin
            state_d = IDLE;
            done_c  = 1'b0;
        end
    end

    always_comb begin
        // p1: sine ROM address presented; p2: ROM data returned and issued.
        vld_p1_d   = req && !flush;
        rest_p1_d  = (note_q == '0);
        vld_p2_d   = vld_p1_q && !flush;
        rest_p2_d  = rest_p1_q;
        out_vld    = vld_p2_q && reset;
        sample_now = rest_p2_q ? '0 : sine_data;
        sample_d   = flush ? '0 : (out_vld ? sample_now : sample_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            note_q   <= '0;
            cnt_q    <= '0;
            fresh_q  <= 1'b0;
            phase_q  <= '0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            note_q   <= note_d;
            cnt_q    <= cnt_d;
            fresh_q  <= fresh_d;
            phase_q  <= phase_d;
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            sample_q <= sample_d;
        end
    end

    always_ff @(posedge clk) begin
        step_q    <= step_d;
        rest_p1_q <= rest_p1_d;
        rest_p2_q <= rest_p2_d;
    end

    assign busy             = (state_q != IDLE);
    assign note_done        = done_c && reset;
    assign freq_addr        = note_q;
    assign sine_addr        = phase_q[PHASE_W-1 -: SINE_AW];
    assign sample_out       = out_vld ? sample_now : sample_q;
    assign new_sample_ready = out_vld;

endmodule

// File: tb/tb_queued_note_player.sv
// Scoreboard bench for queued_note_player; follows NOTE_PLAYER_QUEUE_EN when it is defined.
module tb_queued_note_player;

    localparam int NOTE_W   = 6;
    localparam int DUR_W    = 6;
    localparam int STEP_W   = 20;
    localparam int PHASE_W  = 22;
    localparam int SINE_AW  = 10;
    localparam int SAMPLE_W = 16;
    localparam int QDEPTH   = 4;
`ifdef NOTE_PLAYER_QUEUE_EN
    localparam int LOAD_LAT = 1;
    localparam int ND_EXP   = 9;
`else
    localparam int LOAD_LAT = 0;
    localparam int ND_EXP   = 6;
`endif

    logic                       clk;
    logic                       reset;
    logic                       play_enable;
    logic                       flush;
    logic [NOTE_W-1:0]          note_in;
    logic [DUR_W-1:0]           duration_in;
    logic                       note_valid;
    logic                       note_ready;
    logic                       beat;
    logic                       note_done;
    logic                       busy;
    logic [NOTE_W-1:0]          freq_addr;
    logic [STEP_W-1:0]          step_size;
    logic                       generate_next_sample;
    logic [SINE_AW-1:0]         sine_addr;
    logic signed [SAMPLE_W-1:0] sine_data;
    logic signed [SAMPLE_W-1:0] sample_out;
    logic                       new_sample_ready;

    queued_note_player #(
        .NOTE_W(NOTE_W), .DUR_W(DUR_W), .STEP_W(STEP_W), .PHASE_W(PHASE_W),
        .SINE_AW(SINE_AW), .SAMPLE_W(SAMPLE_W), .QDEPTH(QDEPTH)
    ) dut (
        .clk(clk), .reset(reset), .play_enable(play_enable), .flush(flush),
        .note_in(note_in), .duration_in(duration_in), .note_valid(note_valid),
        .note_ready(note_ready), .beat(beat), .note_done(note_done), .busy(busy),
        .freq_addr(freq_addr), .step_size(step_size),
        .generate_next_sample(generate_next_sample), .sine_addr(sine_addr),
        .sine_data(sine_data), .sample_out(sample_out),
        .new_sample_ready(new_sample_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_pass;
    int nd_total;
    logic [PHASE_W-1:0]  phase_m;
    logic [NOTE_W-1:0]   note_m;
    logic [SAMPLE_W-1:0] sb[$];

    function automatic logic [STEP_W-1:0] step_of(input logic [NOTE_W-1:0] n);
        return STEP_W'(n) << 10;
    endfunction

    function automatic logic [SAMPLE_W-1:0] sine_of(input logic [SINE_AW-1:0] a);
        return SAMPLE_W'(a) * 16'd97 + 16'h0123;
    endfunction

    // Registered ROM models: data follows the address by one cycle.
    always @(posedge clk) begin
        step_size <= step_of(freq_addr);
        sine_data <= $signed(sine_of(sine_addr));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    always @(negedge clk) begin
        if (note_done) nd_total++;
        if (new_sample_ready) begin
            if (sb.size() == 0) check("sample_spurious", 32'(new_sample_ready), 0);
            else check("sample_out", 32'($unsigned(sample_out)), 32'(sb.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic push_note(input logic [NOTE_W-1:0] n, input logic [DUR_W-1:0] d);
        int i = 0;
        note_in = n;
        duration_in = d;
        note_valid = 1'b1;
        #1;
        while (!note_ready && i < 50) begin
            tick();
            i++;
        end
        if (!note_ready) check("push_ready", 32'(note_ready), 1);
        tick();
        note_valid = 1'b0;
    endtask

    task automatic start_note(input logic [NOTE_W-1:0] n, input logic [DUR_W-1:0] d,
                              input bit load_probe);
        int w = 0;
        push_note(n, d);
        while (!busy && w < 20) begin
            tick();
            w++;
        end
        check("load_latency", 32'(w), LOAD_LAT);
        note_m  = n;
        phase_m = '0;
        generate_next_sample = load_probe;
        tick();
        generate_next_sample = 1'b0;
    endtask

    task automatic expect_sample();
        phase_m = phase_m + PHASE_W'(step_of(note_m));
        sb.push_back((note_m == '0) ? SAMPLE_W'(0) : sine_of(phase_m[PHASE_W-1 -: SINE_AW]));
    endtask

    task automatic req_samples(input int n, input bit expect_out);
        repeat (n) begin
            generate_next_sample = 1'b1;
            if (expect_out) expect_sample();
            tick();
        end
        generate_next_sample = 1'b0;
    endtask

    task automatic do_beat(input string tag, input bit exp_done);
        beat = 1'b1;
        #1;
        check(tag, 32'(note_done), 32'(exp_done));
        tick();
        beat = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, busy=%0d", busy);
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_pass = 0; nd_total = 0;
        phase_m = '0; note_m = '0;
        reset = 1'b0; play_enable = 1'b1; flush = 1'b0;
        note_in = '0; duration_in = '0; note_valid = 1'b0;
        beat = 1'b0; generate_next_sample = 1'b0;
        ticks(3);
        check("rst_busy",      32'(busy), 0);
        check("rst_ready",     32'(note_ready), 0);
        check("rst_note_done", 32'(note_done), 0);
        check("rst_nsr",       32'(new_sample_ready), 0);
        check("rst_sample",    32'($unsigned(sample_out)), 0);
        check("rst_freq",      32'(freq_addr), 0);
        reset = 1'b1;
        tick();
        check("ready_after_reset", 32'(note_ready), 1);

        // note 10 for 3 beats, probing that a request during LOAD is ignored
        start_note(10, 3, 1'b1);
        check("freq_addr", 32'(freq_addr), 10);
        req_samples(1, 1'b1);
        ticks(2);
        for (int i = 0; i < 6; i++) begin
            do_beat("done_on_3rd_beat", i == 2);
            if (i == 2) check("busy_after_done", 32'(busy), 0);
            ticks(3);
        end

        // step 0x400, requests every cycle for 8 cycles
        start_note(1, 2, 1'b0);
        for (int k = 0; k <= 10; k++) begin
            generate_next_sample = (k < 8);
            if (k < 8) expect_sample();
            #1;
            check("nsr_pipeline", 32'(new_sample_ready), 32'(k >= 2 && k < 10));
            tick();
        end
        generate_next_sample = 1'b0;
        do_beat("dur2_beat1", 1'b0);
        ticks(2);
        do_beat("dur2_beat2", 1'b1);

`ifdef NOTE_PLAYER_QUEUE_EN
        push_note(3, 1); push_note(4, 1); push_note(5, 1); push_note(6, 1); push_note(7, 0);
        check("queue_full_ready", 32'(note_ready), 0);
        check("queue_busy", 32'(busy), 1);
        note_in = 9; duration_in = 1; note_valid = 1'b1;
        ticks(2);
        note_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ticks(2);
            check("queue_freq", 32'(freq_addr), 3 + k);
            do_beat("queue_done", 1'b1);
        end
        check("queue_drained", 32'(busy), 0);
        ticks(3);
        check("full_push_dropped", 32'(busy), 0);
`else
        start_note(3, 1, 1'b0);
        note_in = 9; duration_in = 1; note_valid = 1'b1;
        #1;
        check("ready_while_busy", 32'(note_ready), 0);
        ticks(2);
        note_valid = 1'b0;
        do_beat("single_done", 1'b1);
        check("single_idle", 32'(busy), 0);
        start_note(7, 0, 1'b0);
        check("dur0_freq", 32'(freq_addr), 7);
        do_beat("dur0_done", 1'b1);
        check("dur0_idle", 32'(busy), 0);
`endif

        // pause mid-note for 20 cycles with beats and requests
        start_note(4, 3, 1'b0);
        req_samples(2, 1'b1);
        ticks(3);
        do_beat("pause_beat1", 1'b0);
        play_enable = 1'b0;
        for (int k = 0; k < 20; k++) begin
            generate_next_sample = 1'b1;
            beat = (k % 4 == 0);
            #1;
            check("pause_note_done", 32'(note_done), 0);
            check("pause_nsr", 32'(new_sample_ready), 0);
            check("pause_busy", 32'(busy), 1);
            tick();
        end
        generate_next_sample = 1'b0;
        beat = 1'b0;
        play_enable = 1'b1;
        req_samples(1, 1'b1);
        ticks(2);
        do_beat("resume_beat2", 1'b0);
        ticks(2);
        do_beat("resume_beat3", 1'b1);

        // flush together with the final beat, a push and an in-flight sample
        start_note(5, 2, 1'b0);
        req_samples(1, 1'b1);
        ticks(3);
        do_beat("flush_beat1", 1'b0);
        req_samples(1, 1'b0);
        flush = 1'b1; beat = 1'b1;
        note_in = 6; duration_in = 1; note_valid = 1'b1;
        #1;
        check("flush_no_done", 32'(note_done), 0);
        tick();
        flush = 1'b0; beat = 1'b0; note_valid = 1'b0;
        check("flush_busy", 32'(busy), 0);
        check("flush_sample", 32'($unsigned(sample_out)), 0);
        check("flush_nsr", 32'(new_sample_ready), 0);
        ticks(3);
        check("flush_stays_idle", 32'(busy), 0);

        // rest note: pulses with zero samples
        start_note(0, 2, 1'b0);
        req_samples(3, 1'b1);
        ticks(2);
        do_beat("rest_beat1", 1'b0);
        ticks(1);
        do_beat("rest_beat2", 1'b1);
        check("rest_idle", 32'(busy), 0);

        // reset in the middle of a note with samples in flight
        start_note(8, 5, 1'b0);
        req_samples(2, 1'b0);
        reset = 1'b0;
        beat = 1'b1;
        #1;
        check("rst_mid_nsr", 32'(new_sample_ready), 0);
        check("rst_mid_ready", 32'(note_ready), 0);
        check("rst_mid_done", 32'(note_done), 0);
        tick();
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_freq", 32'(freq_addr), 0);
        check("rst_mid_sample", 32'($unsigned(sample_out)), 0);
        check("rst_mid_nsr2", 32'(new_sample_ready), 0);
        check("rst_mid_done2", 32'(note_done), 0);
        tick();
        beat = 1'b0;
        reset = 1'b1;
        tick();
        check("rst_release_ready", 32'(note_ready), 1);
        check("rst_release_busy", 32'(busy), 0);

        ticks(4);
        check("note_done_total", 32'(nd_total), ND_EXP);
        check("scoreboard_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
